// File: rtl/neuron_mac.sv
// Serial Q8.8 multiply-accumulate neuron stage with bias add and Q8.8 result.
// Optional macro NEURON_MAC_SATURATE_EN clips the result instead of wrapping it.
module neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] in_x,
  input  logic signed [15:0] in_w,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] bias,
  output logic        [15:0] out_z,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {ACCUM, FINAL, OUT} state_e;

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [CNT_W-1:0]  count_q;
  logic        [15:0]       bias_q;
  logic        [15:0]       out_z_q;
  logic                     out_sat_q;
  logic                     out_valid_q;

  logic signed [31:0]       prod;
  logic signed [ACC_W-1:0]  sum_d;
  logic        [ACC_W-9:0]  r_d;
  logic        [15:0]       z_d;
  logic                     sat_d;

  assign prod = in_x * in_w;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    z_d   = 16'h0000;
    sat_d = 1'b0;
    sum_d = acc_q + {{(ACC_W-24){bias_q[15]}}, bias_q, 8'h00};
    r_d   = sum_d[ACC_W-1:8];
`ifdef NEURON_MAC_SATURATE_EN
    // Upper bits above bit 15 must all equal the sign bit for r to fit in 16 bits.
    if (!r_d[ACC_W-9] && (|r_d[ACC_W-9:15])) begin
      z_d   = 16'h7FFF;
      sat_d = 1'b1;
    end else if (r_d[ACC_W-9] && !(&r_d[ACC_W-9:15])) begin
      z_d   = 16'h8000;
      sat_d = 1'b1;
    end else begin
      z_d = r_d[15:0];
    end
`else
    z_d = r_d[15:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      bias_q      <= '0;
      out_z_q     <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_q   <= acc_q + {{(ACC_W-32){prod[31]}}, prod};
            count_q <= count_q + 1'b1;
            if (count_q == LAST_CNT) begin
              bias_q  <= bias;
              state_q <= FINAL;
            end
          end
        end
        FINAL: begin
          out_z_q     <= z_d;
          out_sat_q   <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_z     = out_z_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized self-checking bench for neuron_mac against an arithmetic reference model.
module tb_neuron_mac;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] in_x;
  logic signed [15:0] in_w;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] bias;
  logic        [15:0] out_z;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] xs [N];
  logic signed [15:0] ws [N];

  neuron_mac #(.N_INPUTS(N), .ACC_W(40)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bias      (bias),
    .out_z     (out_z),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact dot product plus scaled bias, floor-shift, then narrow.
  function automatic logic [16:0] model(input logic signed [15:0] b);
    longint s = 0;
    longint r;
    for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(ws[i]);
    s += longint'(b) * 256;
    r = s >>> 8;
`ifdef NEURON_MAC_SATURATE_EN
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, 16'(r)};
  endfunction

  // Entered and left at a falling edge.
  task automatic run_eval(input logic signed [15:0] b, input int max_gap, input int stall);
    logic [16:0] exp;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      in_x     = xs[i];
      in_w     = ws[i];
      bias     = (i == N - 1) ? b : 16'($urandom);
      in_valid = 1'b1;
      check("accept_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    bias     = 16'($urandom);
    check("final_valid", 32'(out_valid), 32'd0);
    check("final_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    exp = model(b);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      in_x     = 16'($urandom);
      in_w     = 16'($urandom);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_z", 32'(out_z), 32'(exp[15:0]));
    end
    in_valid = 1'b0;
    check("out_z", 32'(out_z), 32'(exp[15:0]));
    check("out_sat", 32'(out_sat), 32'(exp[16]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic fill(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < N; i++) begin
      xs[i] = x;
      ws[i] = w;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_x      = '0;
    in_w      = '0;
    in_valid  = 1'b0;
    bias      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_z", 32'(out_z), 32'h0);
    check("rst_sat", 32'(out_sat), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);

    fill(16'h0100, 16'h0080);
    run_eval(16'h0040, 0, 0);
    fill(16'hFF00, 16'h0200);
    run_eval(16'h0000, 0, 0);
    fill(16'h7FFF, 16'h7FFF);
    run_eval(16'h0000, 0, 0);
    fill(16'h0100, 16'h0080);
    run_eval(16'h0040, 0, 5);
    run_eval(16'h0040, 0, 0);
    run_eval(16'h0040, 3, 0);

    // Reset in the middle of an accumulation discards the partial sum.
    in_x     = 16'h0100;
    in_w     = 16'h7F00;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    run_eval(16'h0040, 0, 0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          xs[i] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
          ws[i] = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
        end else begin
          xs[i] = 16'($urandom);
          ws[i] = 16'($urandom);
        end
      end
      run_eval(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
